// File: rtl/pf_ddr4_odt_lane_ctrl.sv
// Multi-rank DDR4 ODT lane controller.
// Each rank has a shift window that produces GEAR ODT slots per fabric cycle.
// A separate sequencer drives the IOD delay lines (LOAD/MOVE/DIRECTION) for
// absolute seeks and single-step tap moves.
module pf_ddr4_odt_lane_ctrl #(
  parameter int NUM_RANKS = 1,
  parameter int GEAR      = 4,
  parameter int MAX_LAT   = 15,
  parameter int MAX_LEN   = 8,
  parameter int TAP_MAX   = 127,
  parameter int MOVE_GAP  = 2,
  localparam int RW = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1,
  localparam int LW = $clog2(MAX_LAT + 1),
  localparam int NW = $clog2(MAX_LEN + 1),
  localparam int TW = $clog2(TAP_MAX + 1)
) (
  input  logic                      FAB_CLK,
  input  logic                      ARST,
  input  logic                      ODT_REQ,
  input  logic [RW-1:0]             ODT_RANK,
  input  logic [LW-1:0]             CFG_ODT_LAT,
  input  logic [NW-1:0]             CFG_ODT_LEN,
  input  logic [NUM_RANKS-1:0]      CFG_ODT_FORCE,
  output logic [NUM_RANKS*GEAR-1:0] TX_DATA,
  output logic [NUM_RANKS*GEAR-1:0] OE_DATA,
  input  logic                      DLY_START,
  input  logic                      DLY_MODE,
  input  logic [RW-1:0]             DLY_LANE,
  input  logic [TW-1:0]             DLY_TARGET,
  input  logic                      DLY_STEP_DIR,
  output logic                      DLY_BUSY,
  output logic                      DLY_DONE,
  output logic                      DLY_ERR,
  output logic [TW-1:0]             DLY_TAP,
  output logic [NUM_RANKS-1:0]      DELAY_LINE_LOAD,
  output logic [NUM_RANKS-1:0]      DELAY_LINE_MOVE,
  output logic [NUM_RANKS-1:0]      DELAY_LINE_DIRECTION,
  input  logic [NUM_RANKS-1:0]      DELAY_LINE_OUT_OF_RANGE
);

  localparam int WW = (MAX_LAT + MAX_LEN > GEAR) ? (MAX_LAT + MAX_LEN) : GEAR;
  localparam int GW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_MOVE, S_DONE, S_ERR} dly_state_t;

  function automatic logic [LW-1:0] sat_lat(input logic [LW-1:0] v);
    return (int'(v) > MAX_LAT) ? LW'(MAX_LAT) : v;
  endfunction

  function automatic logic [NW-1:0] sat_len(input logic [NW-1:0] v);
    return (int'(v) > MAX_LEN) ? NW'(MAX_LEN) : v;
  endfunction

  // LEN consecutive ones starting LAT slots into the window
  function automatic logic [WW-1:0] odt_mask(input logic [LW-1:0] lat, input logic [NW-1:0] len);
    logic [WW-1:0] ones;
    ones = (WW'(1) << len) - WW'(1);
    return ones << lat;
  endfunction

  logic            req_r;
  logic [RW-1:0]   rank_r;
  logic [LW-1:0]   lat_r;
  logic [NW-1:0]   len_r;
  logic            out_en;
  logic [WW-1:0]   win [NUM_RANKS];

  dly_state_t      state;
  logic [RW-1:0]   lane_q;
  logic            mode_q;
  logic [TW-1:0]   tgt_q;
  logic [TW-1:0]   tap [NUM_RANKS];
  logic [TW-1:0]   tap_prev;
  logic [GW-1:0]   cnt;
  logic [NUM_RANKS-1:0] load_q, move_q, dir_q;
  logic            done_q, err_q;

  logic [TW-1:0]   tap_in, tap_cur;
  logic            oor_cur, start_bad;

  // Request stage, then per-rank window shift with the new window ORed in
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      req_r  <= 1'b0;
      rank_r <= '0;
      lat_r  <= '0;
      len_r  <= '0;
      out_en <= 1'b0;
      for (int r = 0; r < NUM_RANKS; r++) win[r] <= '0;
    end else begin
      req_r  <= ODT_REQ;
      rank_r <= ODT_RANK;
      lat_r  <= sat_lat(CFG_ODT_LAT);
      len_r  <= sat_len(CFG_ODT_LEN);
      out_en <= 1'b1;
      for (int r = 0; r < NUM_RANKS; r++)
        win[r] <= (win[r] >> GEAR) |
                  ((req_r && rank_r == RW'(r)) ? odt_mask(lat_r, len_r) : '0);
    end
  end

  // Lowest GEAR window bits go out this cycle; force is held off until out of reset
  always_comb begin
    TX_DATA = '0;
    for (int r = 0; r < NUM_RANKS; r++)
      TX_DATA[r*GEAR +: GEAR] = win[r][GEAR-1:0] | {GEAR{CFG_ODT_FORCE[r] & out_en}};
  end

  assign OE_DATA = {(NUM_RANKS*GEAR){out_en}};

  // Select tap/range flag of the requested lane and of the latched lane
  always_comb begin
    tap_in  = '0;
    tap_cur = '0;
    oor_cur = 1'b0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (DLY_LANE == RW'(r)) tap_in = tap[r];
      if (lane_q == RW'(r)) begin
        tap_cur = tap[r];
        oor_cur = DELAY_LINE_OUT_OF_RANGE[r];
      end
    end
    start_bad = (int'(DLY_LANE) >= NUM_RANKS) ||
                (!DLY_MODE && int'(DLY_TARGET) > TAP_MAX) ||
                (DLY_MODE && DLY_STEP_DIR && int'(tap_in) == TAP_MAX) ||
                (DLY_MODE && !DLY_STEP_DIR && tap_in == '0);
  end

  // Delay-line sequencer; pulses are registered on entry to their state
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state    <= S_IDLE;
      lane_q   <= '0;
      mode_q   <= 1'b0;
      tgt_q    <= '0;
      tap_prev <= '0;
      cnt      <= '0;
      load_q   <= '0;
      move_q   <= '0;
      dir_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int r = 0; r < NUM_RANKS; r++) tap[r] <= '0;
    end else begin
      load_q <= '0;
      move_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (DLY_START) begin
            lane_q <= DLY_LANE;
            mode_q <= DLY_MODE;
            tgt_q  <= DLY_TARGET;
            if (start_bad) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else begin
              tap_prev <= tap_in;
              for (int r = 0; r < NUM_RANKS; r++) begin
                if (DLY_LANE == RW'(r)) begin
                  if (!DLY_MODE) begin
                    load_q[r] <= 1'b1;
                    tap[r]    <= '0;
                  end else begin
                    move_q[r] <= 1'b1;
                    dir_q[r]  <= DLY_STEP_DIR;
                    tap[r]    <= DLY_STEP_DIR ? tap_in + TW'(1) : tap_in - TW'(1);
                  end
                end
              end
              state <= DLY_MODE ? S_MOVE : S_LOAD;
            end
          end
        end
        S_LOAD, S_MOVE: begin
          state <= S_GAP;
          cnt   <= GW'(MOVE_GAP - 1);
        end
        S_GAP: begin
          if (oor_cur) begin
            for (int r = 0; r < NUM_RANKS; r++)
              if (lane_q == RW'(r)) tap[r] <= tap_prev;
            state <= S_ERR;
            err_q <= 1'b1;
          end else if (cnt == '0) begin
            if (!mode_q && tap_cur != tgt_q) begin
              tap_prev <= tap_cur;
              for (int r = 0; r < NUM_RANKS; r++) begin
                if (lane_q == RW'(r)) begin
                  move_q[r] <= 1'b1;
                  dir_q[r]  <= 1'b1;
                  tap[r]    <= tap_cur + TW'(1);
                end
              end
              state <= S_MOVE;
            end else begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - GW'(1);
          end
        end
        S_DONE, S_ERR: state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

  assign DLY_BUSY             = (state != S_IDLE);
  assign DLY_DONE             = done_q;
  assign DLY_ERR              = err_q;
  assign DLY_TAP              = tap_cur;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_pf_ddr4_odt_lane_ctrl.sv
// Directed bench for pf_ddr4_odt_lane_ctrl: three ranks, GEAR 4, TAP_MAX 100.
module tb_pf_ddr4_odt_lane_ctrl;

  logic        clk = 1'b0;
  logic        arst;
  logic        odt_req;
  logic [1:0]  odt_rank;
  logic [3:0]  cfg_lat;
  logic [3:0]  cfg_len;
  logic [2:0]  cfg_force;
  logic [11:0] tx_data, oe_data;
  logic        dly_start, dly_mode, dly_dir;
  logic [1:0]  dly_lane;
  logic [6:0]  dly_target;
  logic        busy, done, err;
  logic [6:0]  tap;
  logic [2:0]  dl_load, dl_move, dl_dir, dl_oor;

  int vectors = 0;
  int miscompares = 0;

  pf_ddr4_odt_lane_ctrl #(
    .NUM_RANKS(3), .GEAR(4), .MAX_LAT(15), .MAX_LEN(8), .TAP_MAX(100), .MOVE_GAP(2)
  ) dut (
    .FAB_CLK(clk), .ARST(arst),
    .ODT_REQ(odt_req), .ODT_RANK(odt_rank), .CFG_ODT_LAT(cfg_lat), .CFG_ODT_LEN(cfg_len),
    .CFG_ODT_FORCE(cfg_force), .TX_DATA(tx_data), .OE_DATA(oe_data),
    .DLY_START(dly_start), .DLY_MODE(dly_mode), .DLY_LANE(dly_lane), .DLY_TARGET(dly_target),
    .DLY_STEP_DIR(dly_dir), .DLY_BUSY(busy), .DLY_DONE(done), .DLY_ERR(err), .DLY_TAP(tap),
    .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst = 1'b1; odt_req = 0; odt_rank = 0; cfg_lat = 0; cfg_len = 0; cfg_force = 0;
    dly_start = 0; dly_mode = 0; dly_lane = 0; dly_target = 0; dly_dir = 0; dl_oor = 0;
    tick(); tick();
    vectors++;
    if ({tx_data, oe_data, dl_load, dl_move, dl_dir, busy, done, err, tap} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got tx=%h oe=%h busy=%b tap=%0d required all zero", tx_data, oe_data, busy, tap);
    end
    arst = 1'b0;
    #1;
    vectors++;
    if (oe_data !== 12'h000) begin
      miscompares++;
      $display("FAIL oe_before_edge got %h required 000", oe_data);
    end
    tick();
    vectors++;
    if (oe_data !== 12'hFFF || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL oe_after_edge got oe=%h busy=%b required oe=fff busy=0", oe_data, busy);
    end
  endtask

  task automatic test_odt_single();
    logic [11:0] exp_seq [5];
    exp_seq = '{12'h000, 12'h000, 12'h00E, 12'h007, 12'h000};
    cfg_lat = 4'd5; cfg_len = 4'd6; odt_rank = 2'd0; odt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      odt_req = 1'b0;
      vectors++;
      if (tx_data !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL odt_single step=%0d got %h required %h", i, tx_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_odt_union();
    logic [11:0] exp_seq [5];
    exp_seq = '{12'h000, 12'h000, 12'h00F, 12'h007, 12'h000};
    cfg_lat = 4'd5; cfg_len = 4'd6; odt_rank = 2'd0; odt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        cfg_lat = 4'd0; cfg_len = 4'd2; odt_req = 1'b1;
      end else begin
        odt_req = 1'b0;
      end
      vectors++;
      if (tx_data !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL odt_union step=%0d got %h required %h", i, tx_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_odt_rank_clamp();
    logic [11:0] exp_seq [4];
    // rank 1, LEN 12 saturates to 8 slots
    exp_seq = '{12'h000, 12'h0F0, 12'h0F0, 12'h000};
    cfg_lat = 4'd0; cfg_len = 4'd12; odt_rank = 2'd1; odt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      odt_req = 1'b0;
      vectors++;
      if (tx_data !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL odt_len_clamp step=%0d got %h required %h", i, tx_data, exp_seq[i]);
      end
    end
    // rank 3 does not exist, LEN 0 does nothing
    cfg_len = 4'd4; odt_rank = 2'd3; odt_req = 1'b1;
    tick();
    cfg_len = 4'd0; odt_rank = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      odt_req = 1'b0;
      vectors++;
      if (tx_data !== 12'h000) begin
        miscompares++;
        $display("FAIL odt_ignored step=%0d got %h required 000", i, tx_data);
      end
    end
  endtask

  task automatic test_force();
    cfg_force = 3'b101;
    #1;
    vectors++;
    if (tx_data !== 12'hF0F) begin
      miscompares++;
      $display("FAIL odt_force got %h required f0f", tx_data);
    end
    cfg_force = 3'b000;
    #1;
  endtask

  task automatic test_abs_seek();
    logic [2:0] exp_load, exp_move;
    logic       exp_done, exp_busy;
    dly_start = 1; dly_mode = 0; dly_lane = 0; dly_target = 7'd3;
    for (int c = 1; c <= 14; c++) begin
      tick();
      dly_start = 0;
      exp_load = (c == 1) ? 3'b001 : 3'b000;
      exp_move = (c == 4 || c == 7 || c == 10) ? 3'b001 : 3'b000;
      exp_done = (c == 13);
      exp_busy = (c <= 13);
      vectors++;
      if ({dl_load, dl_move, done, err, busy} !== {exp_load, exp_move, exp_done, 1'b0, exp_busy}) begin
        miscompares++;
        $display("FAIL abs_seek c=%0d got load=%b move=%b done=%b err=%b busy=%b required load=%b move=%b done=%b err=0 busy=%b",
                 c, dl_load, dl_move, done, err, busy, exp_load, exp_move, exp_done, exp_busy);
      end
    end
    vectors++;
    if (tap !== 7'd3 || dl_dir !== 3'b001) begin
      miscompares++;
      $display("FAIL abs_seek_tap got tap=%0d dir=%b required tap=3 dir=001", tap, dl_dir);
    end
  endtask

  task automatic test_start_err();
    // step down at tap 0 on lane 1
    dly_start = 1; dly_mode = 1; dly_lane = 2'd1; dly_dir = 0;
    tick();
    dly_start = 0;
    vectors++;
    if ({err, done, dl_move, dl_load, tap} !== {1'b1, 1'b0, 3'b000, 3'b000, 7'd0}) begin
      miscompares++;
      $display("FAIL err_step_down got err=%b move=%b tap=%0d required err=1 move=000 tap=0", err, dl_move, tap);
    end
    tick();
    // absolute target above TAP_MAX on lane 0
    dly_start = 1; dly_mode = 0; dly_lane = 2'd0; dly_target = 7'd120;
    tick();
    dly_start = 0;
    vectors++;
    if ({err, dl_load, dl_move, tap} !== {1'b1, 3'b000, 3'b000, 7'd3}) begin
      miscompares++;
      $display("FAIL err_target got err=%b load=%b tap=%0d required err=1 load=000 tap=3", err, dl_load, tap);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_to_idle got busy=%b err=%b required 0 0", busy, err);
    end
    // lane 3 does not exist
    dly_start = 1; dly_mode = 0; dly_lane = 2'd3; dly_target = 7'd1;
    tick();
    dly_start = 0;
    vectors++;
    if ({err, dl_load, dl_move} !== {1'b1, 3'b000, 3'b000}) begin
      miscompares++;
      $display("FAIL err_lane got err=%b load=%b move=%b required 1 000 000", err, dl_load, dl_move);
    end
    tick();
  endtask

  task automatic test_step();
    // lane 0 at tap 3: up then down
    dly_start = 1; dly_mode = 1; dly_lane = 2'd0; dly_dir = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      dly_start = 0;
      vectors++;
      if ({dl_move, done, busy} !== {(c == 1) ? 3'b001 : 3'b000, c == 4, 1'b1}) begin
        miscompares++;
        $display("FAIL step_up c=%0d got move=%b done=%b busy=%b", c, dl_move, done, busy);
      end
    end
    vectors++;
    if (tap !== 7'd4 || dl_dir !== 3'b001) begin
      miscompares++;
      $display("FAIL step_up_tap got tap=%0d dir=%b required 4 001", tap, dl_dir);
    end
    tick();
    dly_start = 1; dly_dir = 0;
    tick();
    dly_start = 0;
    vectors++;
    if (dl_move !== 3'b001 || dl_dir !== 3'b000 || tap !== 7'd3) begin
      miscompares++;
      $display("FAIL step_down got move=%b dir=%b tap=%0d required 001 000 3", dl_move, dl_dir, tap);
    end
    tick(); tick(); tick(); tick();
    vectors++;
    if (dl_dir !== 3'b000 || busy !== 1'b0 || tap !== 7'd3) begin
      miscompares++;
      $display("FAIL step_down_hold got dir=%b busy=%b tap=%0d required 000 0 3", dl_dir, busy, tap);
    end
  endtask

  task automatic test_oor();
    dly_start = 1; dly_mode = 0; dly_lane = 2'd2; dly_target = 7'd5;
    for (int c = 1; c <= 9; c++) begin
      tick();
      dly_start = 0;
      if (c == 7) begin
        vectors++;
        if (dl_move !== 3'b100 || tap !== 7'd2) begin
          miscompares++;
          $display("FAIL oor_second_move got move=%b tap=%0d required 100 2", dl_move, tap);
        end
        dl_oor = 3'b100;
      end
      if (c == 8) begin
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL oor_gap got err=%b busy=%b required 0 1", err, busy);
        end
      end
    end
    vectors++;
    if (err !== 1'b1 || done !== 1'b0 || tap !== 7'd1) begin
      miscompares++;
      $display("FAIL oor_err got err=%b done=%b tap=%0d required 1 0 1", err, done, tap);
    end
    dl_oor = 3'b000;
    tick();
  endtask

  task automatic test_tap_max();
    int done_at;
    done_at = 0;
    dly_start = 1; dly_mode = 0; dly_lane = 2'd1; dly_target = 7'd100;
    for (int c = 1; c <= 400 && done_at == 0; c++) begin
      tick();
      dly_start = 0;
      if (done === 1'b1) done_at = c;
    end
    vectors++;
    if (done_at != 304 || tap !== 7'd100) begin
      miscompares++;
      $display("FAIL seek_tap_max got done_cycle=%0d tap=%0d required 304 100", done_at, tap);
    end
    tick();
    dly_start = 1; dly_mode = 1; dly_dir = 1;
    tick();
    dly_start = 0;
    vectors++;
    if (err !== 1'b1 || dl_move !== 3'b000 || tap !== 7'd100) begin
      miscompares++;
      $display("FAIL step_up_at_max got err=%b move=%b tap=%0d required 1 000 100", err, dl_move, tap);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    cfg_force = 3'b010;
    dly_start = 1; dly_mode = 0; dly_lane = 2'd0; dly_target = 7'd5;
    for (int c = 1; c <= 4; c++) begin
      tick();
      dly_start = 0;
    end
    vectors++;
    if (dl_move !== 3'b001 || tx_data !== 12'h0F0) begin
      miscompares++;
      $display("FAIL pre_reset got move=%b tx=%h required 001 0f0", dl_move, tx_data);
    end
    #2 arst = 1'b1;
    #1;
    vectors++;
    if ({tx_data, oe_data, dl_load, dl_move, dl_dir, busy, done, err, tap} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got tx=%h oe=%h move=%b dir=%b busy=%b tap=%0d required all zero",
               tx_data, oe_data, dl_move, dl_dir, busy, tap);
    end
    @(negedge clk);
    arst = 1'b0;
    tick();
    vectors++;
    if (oe_data !== 12'hFFF || tx_data !== 12'h0F0 || busy !== 1'b0 || tap !== 7'd0) begin
      miscompares++;
      $display("FAIL after_reset got oe=%h tx=%h busy=%b tap=%0d required fff 0f0 0 0", oe_data, tx_data, busy, tap);
    end
    cfg_force = 3'b000;
    // lane 1 held tap 100 before reset; a step down now must be refused
    dly_start = 1; dly_mode = 1; dly_lane = 2'd1; dly_dir = 0;
    tick();
    dly_start = 0;
    vectors++;
    if (err !== 1'b1 || dl_move !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_taps got err=%b move=%b required 1 000", err, dl_move);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_odt_single();
    test_odt_union();
    test_odt_rank_clamp();
    test_force();
    test_abs_seek();
    test_start_err();
    test_step();
    test_oor();
    test_tap_max();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
